// File: rtl/crc5_query_tx.sv
// Gen2-style Query transmitter: serializes a latched payload MSB first, then
// appends its CRC-5 (x^5+x^3+1, preset 01001) over a per-bit valid/ready handshake.
module crc5_query_tx #(
    parameter int         PAYLOAD_W  = 17,
    parameter logic [4:0] CRC_PRESET = 5'b01001
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PAYLOAD_W-1:0] payload,
    output logic                 bit_out,
    output logic                 bit_valid,
    input  logic                 bit_ready,
    output logic                 busy,
    output logic                 done,
    output logic [4:0]           crc_out
);

    localparam int CNT_W = $clog2(PAYLOAD_W + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_DATA = 2'd1,
        SEND_CRC  = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t                 state_q,   state_d;
    logic [PAYLOAD_W-1:0]   shreg_q,   shreg_d;
    logic [4:0]             crc_q,     crc_d;
    logic [4:0]             crc_out_q, crc_out_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic                   busy_q,    busy_d;
    logic [4:0]             crc_upd;

    // One serial step of the x^5+x^3+1 LFSR with bit b entering at the top.
    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
        logic fb;
        fb = b ^ c[4];
        return {c[3], c[2] ^ fb, c[1], c[0], fb};
    endfunction

    assign crc_upd = crc5_step(crc_q, shreg_q[PAYLOAD_W-1]);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        crc_d     = crc_q;
        crc_out_d = crc_out_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        bit_out   = 1'b0;
        bit_valid = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = payload;
                    crc_d   = CRC_PRESET;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SEND_DATA;
                end
            end
            SEND_DATA: begin
                bit_valid = 1'b1;
                bit_out   = shreg_q[PAYLOAD_W-1];
                if (bit_ready) begin
                    crc_d   = crc_upd;
                    shreg_d = shreg_q << 1;
                    if (cnt_q == CNT_W'(PAYLOAD_W - 1)) begin
                        cnt_d     = '0;
                        crc_out_d = crc_upd;
                        state_d   = SEND_CRC;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            SEND_CRC: begin
                // crc_q is a working copy shifted out; crc_out keeps the result.
                bit_valid = 1'b1;
                bit_out   = crc_q[4];
                if (bit_ready) begin
                    crc_d = {crc_q[3:0], 1'b0};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(4)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            crc_q     <= CRC_PRESET;
            crc_out_q <= CRC_PRESET;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            crc_q     <= crc_d;
            crc_out_q <= crc_out_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign crc_out = crc_out_q;

endmodule

// File: doc/crc5_query_tx.md
Name: crc5_query_tx

Overview:
- Reader-side transmitter for the Gen2-style Query command: latches a PAYLOAD_W-bit payload and serializes it MSB first.
- Computes CRC-5 over the payload bits as they go out and appends the 5 CRC bits, MSB first.
- CRC-5 uses polynomial x^5+x^3+1 with preset 5'b01001, no output inversion. The tag-side CRC-5 checker therefore sees an all-zero residue after all PAYLOAD_W+5 bits.
- Sits between the reader command builder and the PIE modulator; uses a per-bit valid/ready handshake.

Parameters:
- PAYLOAD_W, 17, payload bits before CRC (Query = cmd 4 + DR 1 + M 2 + TRext 1 + Sel 2 + Session 2 + Target 1 + Q 4).
- CRC_PRESET, 5'b01001, CRC register value loaded at start of each frame.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- payload  in  PAYLOAD_W  command bits; payload[PAYLOAD_W-1] is sent first; latched on the accepted start.
- bit_out  out  1  current serial bit.
- bit_valid  out  1  bit_out is valid.
- bit_ready  in  1  modulator accepts bit_out this cycle.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the last CRC bit is accepted.
- crc_out  out  5  CRC over the payload; stable from entry to SEND_CRC until the next accepted start.

Behaviour:
- Reset values (and state after reset): state=IDLE, bit_out=0, bit_valid=0, busy=0, done=0, crc_out=CRC_PRESET, bit counter=0.
- Reset asserted mid-frame aborts on the next edge to the reset values; no done pulse; the remaining bits are never presented.
- State IDLE:
  - On start=1: latch payload into the shift register, crc<=CRC_PRESET, counter<=0, busy<=1, go to SEND_DATA.
  - start=0: stay in IDLE.
  - start while not IDLE is ignored.
- State SEND_DATA:
  - bit_valid=1; bit_out=shreg[PAYLOAD_W-1].
  - On handshake (bit_valid & bit_ready), with b = the bit sent and c = current crc:
    - crc[0]<=b^c[4]; crc[1]<=c[0]; crc[2]<=c[1]; crc[3]<=c[2]^b^c[4]; crc[4]<=c[3].
    - Shift shreg left; counter++.
  - The handshake on bit PAYLOAD_W-1 moves to SEND_CRC with counter<=0; crc_out takes the updated crc in that same edge.
  - bit_ready=0: hold bit_out, bit_valid, crc and counter unchanged (no combinational path from bit_ready to bit_out).
- State SEND_CRC:
  - bit_valid=1; bit_out=crc[4].
  - On handshake: shift the crc copy left (zero fill); crc_out is unchanged; counter++.
  - The handshake on bit 4 moves to DONE.
- State DONE: bit_valid=0, done=1 for exactly one cycle, busy<=0, then IDLE.
- A start in the DONE cycle is ignored. The earliest accepted start is the first IDLE cycle.
- Timing and totals:
  - Start accepted at edge N gives bit_valid=1 from cycle N+1.
  - With bit_ready tied high, the frame is PAYLOAD_W+5 cycles of bit_valid, then the done pulse. For PAYLOAD_W=17: 22 cycles, done on cycle N+23.
- Counter width is ceil(log2(PAYLOAD_W+1)); no wrap occurs within a frame.

Test Plan:
- payload=17'h00000, bit_ready=1 -> bit_out is 17 zeros then 0,0,1,1,1; crc_out=5'b00111; done exactly one pulse, 23 cycles after start.
- Golden loop: feed every accepted bit of a random payload into a CRC-5 model preset 01001 -> residue 5'b00000 after 22 bits; repeat 1000 payloads, including 17'h1FFFF and 17'h10000.
- Backpressure: bit_ready random at 30% duty -> bit stream and crc_out identical to the bit_ready=1 run; bit_out stable while bit_valid & ~bit_ready.
- start pulsed during SEND_DATA with a different payload -> ignored; the original frame completes unchanged; busy stays 1.
- reset asserted after the 9th accepted bit -> next edge: bit_valid=0, busy=0, crc_out=01001, no done; a new start afterwards sends a full clean frame.
- Back-to-back frames: start in the DONE cycle ignored; start on the following IDLE cycle accepted -> second frame correct.
